// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for a serial DAC: captures one generator sample per frame,
// left-justifies it to the DAC code width and shifts the frame out MSB-first.
module dac_spi_tx #(
  parameter int DATA_W  = 9,
  parameter int DAC_W   = 10,
  parameter int LSB_PAD = 2,
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(FRAME_W) + 1;
  localparam int GAP_W = $clog2(GAP_CYC) + 1;

  if (DAC_W < DATA_W || FRAME_W < DAC_W + LSB_PAD || CLK_DIV < 1 || GAP_CYC < 1) begin : g_param_err
    $fatal(1, "dac_spi_tx: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               phase_q, phase_d;   // 0: sclk high half, 1: sclk low half

  logic [DAC_W-1:0]   code;
  logic [FRAME_W-1:0] frame_word;
  logic               div_last, bit_last, gap_last;

  assign code       = DAC_W'(din) << (DAC_W - DATA_W);
  assign frame_word = FRAME_W'(code) << LSB_PAD;

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_last = (bit_q == BIT_W'(FRAME_W - 1));
  assign gap_last = (gap_q == GAP_W'(GAP_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          shreg_d = frame_word;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_last) begin
          div_d   = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_last) begin
          div_d = '0;
          if (!phase_q) begin
            // Falling edge: next bit appears; after the last bit only zeros remain.
            phase_d = 1'b1;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          end else begin
            phase_d = 1'b0;
            if (bit_last) begin
              bit_d   = '0;
              gap_d   = '0;
              state_d = GAP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_last) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign din_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cs_n       = !((state_q == SETUP) || (state_q == SHIFT));
  assign sclk       = (state_q == SHIFT) && !phase_q;
  assign mosi       = shreg_q[FRAME_W-1] & ~cs_n;
  assign frame_done = (state_q == GAP) && (gap_q == '0);

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: default instance plus a CLK_DIV=1/GAP_CYC=1 instance,
// with a negedge monitor recording SPI bits, cs_n widths, capture spacing and timing rules.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] din_a, din_b;
  logic valid_a, valid_b;
  logic ready_a, sclk_a, cs_n_a, mosi_a, busy_a, done_a;
  logic ready_b, sclk_b, cs_n_b, mosi_b, busy_b, done_b;

  dac_spi_tx dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .busy(busy_a), .frame_done(done_a)
  );

  dac_spi_tx #(.CLK_DIV(1), .GAP_CYC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .busy(busy_b), .frame_done(done_b)
  );

  int checks = 0;
  int failures = 0;

  logic s_w [2], c_w [2], m_w [2], f_w [2], v_w [2], r_w [2];
  assign s_w[0] = sclk_a;  assign s_w[1] = sclk_b;
  assign c_w[0] = cs_n_a;  assign c_w[1] = cs_n_b;
  assign m_w[0] = mosi_a;  assign m_w[1] = mosi_b;
  assign f_w[0] = done_a;  assign f_w[1] = done_b;
  assign v_w[0] = valid_a; assign v_w[1] = valid_b;
  assign r_w[0] = ready_a; assign r_w[1] = ready_b;

  logic [15:0] rx [2] = '{16'h0, 16'h0};
  logic p_sclk [2] = '{1'b0, 1'b0};
  logic p_cs   [2] = '{1'b1, 1'b1};
  logic p_mosi [2] = '{1'b0, 1'b0};
  logic p_rdy  [2] = '{1'b1, 1'b1};
  int cyc = 0;
  int rises [2] = '{0, 0};
  int run [2] = '{0, 0};
  int last_run [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  int ready_gap [2] = '{0, 0};
  int cap_cnt [2] = '{0, 0};
  int cap_cyc [2] = '{0, 0};
  int cap_gap [2] = '{0, 0};
  int last_rise [2] = '{0, 0};
  int rise_per [2] = '{0, 0};
  int viol [2] = '{0, 0};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      p_sclk[i] <= s_w[i];
      p_cs[i]   <= c_w[i];
      p_mosi[i] <= m_w[i];
      p_rdy[i]  <= r_w[i];
      if (!p_sclk[i] && s_w[i]) begin
        rises[i]     <= rises[i] + 1;
        rx[i]        <= {rx[i][14:0], m_w[i]};
        rise_per[i]  <= cyc - last_rise[i];
        last_rise[i] <= cyc;
      end
      if ((p_sclk[i] && s_w[i] && (m_w[i] !== p_mosi[i])) ||
          ((c_w[i] !== p_cs[i]) && (s_w[i] !== 1'b0)))
        viol[i] <= viol[i] + 1;
      if (c_w[i] === 1'b0) run[i] <= run[i] + 1;
      else if (p_cs[i] === 1'b0) begin
        last_run[i] <= run[i];
        run[i]      <= 0;
      end
      if (f_w[i] === 1'b1) begin
        done_cnt[i] <= done_cnt[i] + 1;
        done_cyc[i] <= cyc;
      end
      if (!p_rdy[i] && r_w[i]) ready_gap[i] <= cyc - done_cyc[i];
      if (v_w[i] && r_w[i]) begin
        cap_cnt[i] <= cap_cnt[i] + 1;
        cap_gap[i] <= cyc - cap_cyc[i];
        cap_cyc[i] <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int get_cnt(input int w, input int kind);
    case (kind)
      0:       return cap_cnt[w];
      1:       return done_cnt[w];
      default: return rises[w];
    endcase
  endfunction

  task automatic wait_ge(input int w, input int kind, input int target, input string tag);
    int k = 0;
    while (get_cnt(w, kind) < target && k < 500) begin
      tick(1);
      k++;
    end
    chk(tag, get_cnt(w, kind) >= target, 1);
  endtask

  int c0, d0, r0, k;

  initial begin
    din_a = '0; valid_a = 1'b0; din_b = '0; valid_b = 1'b0;
    tick(3);
    $display("step reset: held low");
    chk("rst_cs_n", cs_n_a, 1);
    chk("rst_sclk", sclk_a, 0);
    chk("rst_mosi", mosi_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_frame_done", done_a, 0);
    rst_n = 1'b1;
    tick(1);
    chk("rst_ready", ready_a, 1);
    chk("rst_busy_b", busy_b, 0);

    $display("step frame din=1ff single pulse");
    c0 = cap_cnt[0]; d0 = done_cnt[0]; r0 = rises[0];
    din_a = 9'h1FF; valid_a = 1'b1;
    tick(1);
    valid_a = 1'b0; din_a = 9'h000;
    chk("f1_busy", busy_a, 1);
    chk("f1_ready_low", ready_a, 0);
    wait_ge(0, 1, d0 + 1, "f1_done_seen");
    chk("f1_bits", rx[0], 16'h0FF8);
    chk("f1_cs_low", last_run[0], 66);
    chk("f1_rises", rises[0] - r0, 16);
    chk("f1_sclk_period", rise_per[0], 4);
    tick(8);
    chk("f1_ready_after_gap", ready_gap[0], 4);
    chk("f1_done_once", done_cnt[0] - d0, 1);
    chk("f1_one_capture", cap_cnt[0] - c0, 1);

    $display("step back-to-back din=100 then 000");
    c0 = cap_cnt[0]; d0 = done_cnt[0];
    din_a = 9'h100; valid_a = 1'b1;
    wait_ge(0, 0, c0 + 1, "f2_cap");
    din_a = 9'h155;
    tick(20);
    din_a = 9'h000;
    wait_ge(0, 1, d0 + 1, "f2_done_seen");
    chk("f2_bits", rx[0], 16'h0800);
    wait_ge(0, 0, c0 + 2, "f3_cap");
    valid_a = 1'b0;
    chk("f3_capture_period", cap_gap[0], 71);
    wait_ge(0, 1, d0 + 2, "f3_done_seen");
    chk("f3_bits", rx[0], 16'h0000);
    chk("f3_cs_low", last_run[0], 66);
    tick(8);

    $display("step valid pulsed while busy");
    c0 = cap_cnt[0]; d0 = done_cnt[0];
    din_a = 9'h033; valid_a = 1'b1;
    tick(1);
    valid_a = 1'b0;
    tick(10);
    din_a = 9'h1FF; valid_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("busy_ready_low", ready_a, 0);
      tick(1);
    end
    valid_a = 1'b0;
    wait_ge(0, 1, d0 + 1, "f4_done_seen");
    chk("f4_bits", rx[0], 16'h0198);
    tick(30);
    chk("f4_no_extra_cap", cap_cnt[0] - c0, 1);
    chk("f4_no_extra_done", done_cnt[0] - d0, 1);
    chk("f4_idle", busy_a, 0);

    $display("step reset at 8th sclk rise");
    d0 = done_cnt[0]; r0 = rises[0];
    din_a = 9'h1FF; valid_a = 1'b1;
    tick(1);
    valid_a = 1'b0;
    k = 0;
    while (rises[0] - r0 < 8 && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("abort_reach_rise8", rises[0] - r0, 8);
    chk("abort_sclk_high", sclk_a, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", cs_n_a, 1);
    chk("abort_sclk", sclk_a, 0);
    chk("abort_mosi", mosi_a, 0);
    chk("abort_busy", busy_a, 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    chk("abort_no_done", done_cnt[0] - d0, 0);
    d0 = done_cnt[0]; r0 = rises[0];
    din_a = 9'h0AA; valid_a = 1'b1;
    tick(1);
    valid_a = 1'b0;
    wait_ge(0, 1, d0 + 1, "f5_done_seen");
    chk("f5_bits", rx[0], 16'h0550);
    chk("f5_cs_low", last_run[0], 66);
    chk("f5_rises", rises[0] - r0, 16);
    tick(8);

    $display("step CLK_DIV=1 GAP_CYC=1 valid held");
    c0 = cap_cnt[1]; d0 = done_cnt[1];
    din_b = 9'h1FF; valid_b = 1'b1;
    wait_ge(1, 0, c0 + 2, "b_cap2");
    valid_b = 1'b0;
    chk("b_capture_period", cap_gap[1], 35);
    chk("b_cs_low", last_run[1], 33);
    chk("b_sclk_period", rise_per[1], 2);
    wait_ge(1, 1, d0 + 2, "b_done2");
    chk("b_bits", rx[1], 16'h0FF8);
    tick(5);

    $display("step timing rules");
    chk("timing_a", viol[0], 0);
    chk("timing_b", viol[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
